// File: rtl/trng_pkg.sv
// ---------------------------------------------------------------------------
// trng_pkg
// Shared types and constants for the TRNG request arbiter.
//   - trng_state_e : arbiter FSM states (FAULT only reachable with the
//                    TRNG_HEALTH_EN build macro)
//   - TRNG_BYTE_W  : width of the TRNG byte stream
//   - default REFRESH_CYCLES / REP_LIMIT values
// ---------------------------------------------------------------------------
package trng_pkg;

    localparam int TRNG_BYTE_W             = 8;
    localparam int TRNG_REFRESH_CYCLES_DEF = 9;
    localparam int TRNG_REP_LIMIT_DEF      = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DELIVER = 2'd2,
        ST_FAULT   = 2'd3
    } trng_state_e;

endpackage

// File: rtl/trng_rr_pick.sv
// ---------------------------------------------------------------------------
// trng_rr_pick
// Combinational round-robin picker: selects the first set bit of eff_req_i
// searching upward from rr_ptr_i, wrapping modulo NUM_REQ.
// Ports:
//   eff_req_i [NUM_REQ] : requests eligible this cycle
//   rr_ptr_i  [IDX_W]   : index with highest priority
//   grant_o   [NUM_REQ] : one-hot winner (all zero when no request)
//   idx_o     [IDX_W]   : index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module trng_rr_pick
    import trng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eff_req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic found_s;
    int   pos_s;

    // Rotating priority search; found_s blocks every candidate after the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos_s          = int'(rr_ptr_i) + i;
            pos_s          = (pos_s >= NUM_REQ) ? (pos_s - NUM_REQ) : pos_s;
            grant_o[pos_s] = ~found_s & eff_req_i[pos_s];
            idx_o          = (~found_s & eff_req_i[pos_s]) ? IDX_W'(pos_s) : idx_o;
            found_s        = found_s | eff_req_i[pos_s];
        end
    end

endmodule

// File: rtl/trng_req_arbiter.sv
// ---------------------------------------------------------------------------
// trng_req_arbiter
// Shares one TRNG byte stream among NUM_REQ consumers. A byte is delivered
// only after REFRESH_CYCLES edges of new entropy since the last delivery;
// grants rotate round-robin.
// Build macro: TRNG_HEALTH_EN enables the repetition-count health test and
// the absorbing FAULT state; without it health_fail is constant 0.
// Ports:
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-high
//   trng_byte   : random byte from the trng instance
//   req         : level requests, held until acked
//   ack         : registered one-hot, one-cycle pulse qualifying rdata
//   rdata       : delivered byte, valid while any ack bit is high
//   busy        : registered, high whenever the FSM is not IDLE
//   health_fail : sticky health-test failure
// ---------------------------------------------------------------------------
module trng_req_arbiter
    import trng_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int REFRESH_CYCLES = TRNG_REFRESH_CYCLES_DEF,
    parameter int REP_LIMIT      = TRNG_REP_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TRNG_BYTE_W-1:0] trng_byte,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     ack,
    output logic [TRNG_BYTE_W-1:0] rdata,
    output logic                   busy,
    output logic                   health_fail
);

    localparam int                CNT_W     = $clog2(REFRESH_CYCLES + 1);
    localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0]  FRESH_MAX = CNT_W'(REFRESH_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    // Out-of-range parameters elaborate this empty marker block so they are
    // easy to spot in an elaborated hierarchy.
    if (NUM_REQ < 2 || NUM_REQ > 8 || REFRESH_CYCLES < 2 || REP_LIMIT < 1) begin : g_param_out_of_range
    end

    trng_state_e            state_q, state_d;
    logic [CNT_W-1:0]       fresh_cnt_q, fresh_cnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [TRNG_BYTE_W-1:0] rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   health_fail_q, health_fail_d;

    logic [NUM_REQ-1:0]     eff_req_s;
    logic                   fresh_s;
    logic                   grant_s;
    logic [NUM_REQ-1:0]     pick_grant_s;
    logic [IDX_W-1:0]       pick_idx_s;

    // The requester currently being acked is masked so it may drop late.
    assign eff_req_s = req & ~ack_q;
    assign fresh_s   = (fresh_cnt_q == FRESH_MAX);

    trng_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eff_req_i (eff_req_s),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_grant_s),
        .idx_o     (pick_idx_s)
    );

`ifdef TRNG_HEALTH_EN
    localparam int               REP_W   = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [TRNG_BYTE_W-1:0] prev_byte_q;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;

    // Repetition count of consecutive equal bytes, saturating at REP_LIMIT.
    always_comb begin
        rep_cnt_d     = (trng_byte == prev_byte_q)
                        ? ((rep_cnt_q == REP_MAX) ? rep_cnt_q : rep_cnt_q + REP_W'(1))
                        : '0;
        health_fail_d = health_fail_q | (rep_cnt_d == REP_MAX);
    end

    // Health-test state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_byte_q   <= '0;
            rep_cnt_q     <= '0;
            health_fail_q <= 1'b0;
        end else begin
            prev_byte_q   <= trng_byte;
            rep_cnt_q     <= rep_cnt_d;
            health_fail_q <= health_fail_d;
        end
    end
`else
    assign health_fail_d = 1'b0;
    assign health_fail_q = 1'b0;
`endif

    // Next-state, grant and datapath next values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (eff_req_s != '0) begin
                    state_d = fresh_s ? ST_DELIVER : ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELIVER: begin
                // fresh_cnt was just cleared, so DELIVER never repeats.
                state_d = (eff_req_s != '0) ? ST_COLLECT : ST_IDLE;
            end
`ifdef TRNG_HEALTH_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef TRNG_HEALTH_EN
        state_d = health_fail_d ? ST_FAULT : state_d;
`endif

        // Entering DELIVER is the grant edge (DELIVER cannot follow itself).
        grant_s     = (state_d == ST_DELIVER);
        ack_d       = grant_s ? pick_grant_s : '0;
        rdata_d     = grant_s ? trng_byte : rdata_q;
        rr_ptr_d    = grant_s ? ((pick_idx_s == LAST_IDX) ? '0 : pick_idx_s + IDX_W'(1))
                              : rr_ptr_q;
        fresh_cnt_d = grant_s ? '0
                              : (fresh_s ? fresh_cnt_q : fresh_cnt_q + CNT_W'(1));
        busy_d      = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fresh_cnt_q <= '0;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fresh_cnt_q <= fresh_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_trng_req_arbiter
// Directed and randomized stimulus for trng_req_arbiter, checked against a
// cycle-level reference model: a delivery happens at an edge exactly when
// some unmasked request is present and at least REFRESH_CYCLES edges have
// elapsed since the previous delivery (or reset).
// ---------------------------------------------------------------------------
module tb_trng_req_arbiter;

    localparam int N = 4;
    localparam int R = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] trng_byte = 8'h00;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic [7:0] rdata;
    logic       busy;
    logic       health_fail;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         m_cnt;
    int         m_ptr;
    logic [3:0] m_ack;
    logic [7:0] m_rdata;
    logic       m_busy;
    logic [7:0] last_byte;

    trng_req_arbiter #(
        .NUM_REQ        (N),
        .REFRESH_CYCLES (R),
        .REP_LIMIT      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trng_byte   (trng_byte),
        .req         (req),
        .ack         (ack),
        .rdata       (rdata),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_ptr   = 0;
        m_ack   = 4'b0000;
        m_rdata = 8'h00;
        m_busy  = 1'b0;
    endtask

    // One clock edge of the reference model.
    task automatic model_edge(input logic [3:0] r, input logic [7:0] b);
        logic [3:0] eff;
        logic [3:0] nack;
        int         g;
        eff  = r & ~m_ack;
        nack = 4'b0000;
        g    = -1;
        if (eff != 4'b0000 && m_cnt >= R) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && eff[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
            nack    = 4'(1 << g);
            m_ptr   = (g + 1) % N;
            m_rdata = b;
            m_cnt   = 0;
        end else if (m_cnt < R) begin
            m_cnt++;
        end
        m_busy = (eff != 4'b0000);
        m_ack  = nack;
    endtask

    // Drive inputs, take one edge, update model, compare just after the edge.
    task automatic step(input logic [3:0] r);
        req       = r;
        trng_byte = 8'($urandom);
        last_byte = trng_byte;
        @(posedge clk);
        model_edge(r, last_byte);
        #1;
        check("ack", {28'd0, ack}, {28'd0, m_ack});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("health_fail", {31'd0, health_fail}, 32'd0);
        if (m_ack != 4'b0000) check("rdata", {24'd0, rdata}, {24'd0, m_rdata});
    endtask

    initial begin
        logic [3:0] rr;
        model_reset();

        // reset state
        @(posedge clk);
        #1;
        check("reset_ack", {28'd0, ack}, 32'd0);
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_health", {31'd0, health_fail}, 32'd0);
        reset = 1'b0;

        // start-up grant: req[0] held from release, ack after edge 10
        for (int e = 1; e <= 10; e++) begin
            step(4'b0001);
            if (e == 10) begin
                check("startup_ack", {28'd0, ack}, 32'h1);
                check("startup_rdata", {24'd0, rdata}, {24'd0, last_byte});
            end else begin
                check("startup_quiet", {28'd0, ack}, 32'd0);
            end
        end

        // mid-operation reset during the DELIVER cycle
        reset = 1'b1;
        #1;
        check("midrst_ack", {28'd0, ack}, 32'd0);
        check("midrst_rdata", {24'd0, rdata}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // round-robin sweep from reset: grants every 10 edges, order 0,1,2,3,...
        for (int e = 1; e <= 70; e++) begin
            step(4'b1111);
            if (e % 10 == 0) check("rr_order", {28'd0, ack}, 32'(1 << ((e / 10 - 1) % 4)));
        end

        // pointer skip: pointer sits at 3, only req[1] present
        for (int e = 71; e <= 80; e++) begin
            step(4'b0010);
            if (e == 80) check("ptr_skip", {28'd0, ack}, 32'h2);
        end
        for (int e = 81; e <= 90; e++) begin
            step(4'b1111);
            if (e == 90) check("ptr_after_skip", {28'd0, ack}, 32'h4);
        end

        // request drop: req[2] for 4 cycles after a grant, then released
        for (int e = 91; e <= 104; e++) begin
            step((e <= 94) ? 4'b0100 : 4'b0000);
            check("drop_no_ack", {28'd0, ack}, 32'd0);
        end
        check("drop_idle", {31'd0, busy}, 32'd0);

        // randomized requests against the model
        rr = 4'b0000;
        for (int e = 0; e < 600; e++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            end
            step(rr);
        end

`ifdef TRNG_HEALTH_EN
        // health failure: constant byte, then no more acks until reset
        req       = 4'b1111;
        trng_byte = 8'hA5;
        for (int e = 0; e < 40; e++) @(posedge clk);
        #1;
        check("health_set", {31'd0, health_fail}, 32'd1);
        check("health_busy", {31'd0, busy}, 32'd1);
        for (int e = 0; e < 30; e++) begin
            trng_byte = 8'($urandom);
            @(posedge clk);
            #1;
            check("health_no_ack", {28'd0, ack}, 32'd0);
        end
        check("health_sticky", {31'd0, health_fail}, 32'd1);
        reset = 1'b1;
        #1;
        check("health_clear", {31'd0, health_fail}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
